alu_issue_ctrl: RTL and testbench

//  Operation issuer for the combinational 8-bit ALU. Accepts register-to-register or

---
 rtl/alu_issue_ctrl_if.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 91 +++++++++
 tb/tb_alu_issue_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, ALU, write-back and debug signals of the ALU issuer.
// master is the surrounding environment (instruction source and ALU); slave is the issuer.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int RW    = 2
);
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       instr_op;
    logic [RW-1:0]    instr_rd;
    logic [RW-1:0]    instr_rs1;
    logic [RW-1:0]    instr_rs2;
    logic             instr_imm_en;
    logic [WIDTH-1:0] instr_imm;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             wb_valid;
    logic [RW-1:0]    wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             zero_flag;
    logic [RW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm_en, instr_imm,
        output alu_result, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, zero_flag, dbg_data
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm_en, instr_imm,
        input  alu_result, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, zero_flag, dbg_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external ALU: read rf, drive operands for
// ALU_LATENCY+1 cycles, capture the result and write it back.
module alu_issue_ctrl #(
    parameter int WIDTH       = 8,
    parameter int NREGS       = 4,
    parameter int ALU_LATENCY = 0
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.slave bus
);
    localparam int RW = $clog2(NREGS);
    localparam int CW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t                       state_q, state_d;
    logic [2:0]                   op_q;
    logic [RW-1:0]                rd_q;
    logic [WIDTH-1:0]             a_q, b_q;
    logic [CW-1:0]                cnt_q;
    logic [WIDTH-1:0]             res_q;
    logic [RW-1:0]                wb_rd_q;
    logic                         zero_q;
    logic [NREGS-1:0][WIDTH-1:0]  rf_q;
    logic                         hs;

    assign hs = bus.instr_valid && (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.instr_valid) state_d = EXEC;
            EXEC:    if (cnt_q == '0) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are only presented to the ALU while executing; zero otherwise.
    assign bus.instr_ready = (state_q == IDLE);
    assign bus.alu_a       = (state_q == EXEC) ? a_q  : '0;
    assign bus.alu_b       = (state_q == EXEC) ? b_q  : '0;
    assign bus.alu_op      = (state_q == EXEC) ? op_q : '0;
    assign bus.wb_valid    = (state_q == WB);
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = res_q;
    assign bus.zero_flag   = zero_q;
    assign bus.dbg_data    = rf_q[bus.dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            wb_rd_q <= '0;
            zero_q  <= 1'b0;
            rf_q    <= '0;
        end else begin
            if (hs) begin
                op_q  <= bus.instr_op;
                rd_q  <= bus.instr_rd;
                a_q   <= rf_q[bus.instr_rs1];
                b_q   <= bus.instr_imm_en ? bus.instr_imm : rf_q[bus.instr_rs2];
                cnt_q <= CW'(ALU_LATENCY);
            end
            // wb_data/wb_rd update as the result is captured, so they already show
            // the new value during WB and then hold it.
            if (state_q == EXEC) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CW'(1);
                end else begin
                    res_q   <= bus.alu_result;
                    wb_rd_q <= rd_q;
                end
            end
            if (state_q == WB) begin
                rf_q[rd_q] <= res_q;
                zero_q     <= (res_q == '0);
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl at ALU_LATENCY 0 and 2, with a write-back scoreboard.
module tb_alu_issue_ctrl;
    localparam int W  = 8;
    localparam int RW = 2;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [W-1:0]  data;
    } wb_t;

    logic clk = 1'b0;
    logic rst0, rst2;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(W), .RW(RW)) bus0 ();
    alu_issue_ctrl_if #(.WIDTH(W), .RW(RW)) bus2 ();

    alu_issue_ctrl #(.WIDTH(W), .NREGS(4), .ALU_LATENCY(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    alu_issue_ctrl #(.WIDTH(W), .NREGS(4), .ALU_LATENCY(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b;
            3'd6:    return a >> b;
            default: return (a == b) ? 8'hFF : 8'h00;
        endcase
    endfunction

    assign bus0.alu_result = alu_f(bus0.alu_op, bus0.alu_a, bus0.alu_b);
    assign bus2.alu_result = alu_f(bus2.alu_op, bus2.alu_a, bus2.alu_b);

    logic [2:0]    f_op;
    logic [RW-1:0] f_rd, f_rs1, f_rs2, f_dbg;
    logic          f_ie;
    logic [W-1:0]  f_imm;
    logic          v0, v2, sel;

    assign bus0.instr_valid = v0;    assign bus2.instr_valid = v2;
    assign bus0.instr_op    = f_op;  assign bus2.instr_op    = f_op;
    assign bus0.instr_rd    = f_rd;  assign bus2.instr_rd    = f_rd;
    assign bus0.instr_rs1   = f_rs1; assign bus2.instr_rs1   = f_rs1;
    assign bus0.instr_rs2   = f_rs2; assign bus2.instr_rs2   = f_rs2;
    assign bus0.instr_imm_en= f_ie;  assign bus2.instr_imm_en= f_ie;
    assign bus0.instr_imm   = f_imm; assign bus2.instr_imm   = f_imm;
    assign bus0.dbg_addr    = f_dbg; assign bus2.dbg_addr    = f_dbg;

    wire          obs_ready = sel ? bus2.instr_ready : bus0.instr_ready;
    wire [W-1:0]  obs_a     = sel ? bus2.alu_a       : bus0.alu_a;
    wire [W-1:0]  obs_b     = sel ? bus2.alu_b       : bus0.alu_b;
    wire [2:0]    obs_op    = sel ? bus2.alu_op      : bus0.alu_op;
    wire          obs_wbv   = sel ? bus2.wb_valid    : bus0.wb_valid;

    int  total = 0;
    int  bad   = 0;
    int  hs;
    wb_t q0[$], q2[$];
    wb_t e0, e2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: every write-back strobe must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (bus0.wb_valid === 1'b1) begin
            if (q0.size() == 0) chk("wb0_spurious", bus0.wb_valid, 0);
            else begin
                e0 = q0.pop_front();
                chk("wb0_rd", bus0.wb_rd, e0.rd);
                chk("wb0_data", bus0.wb_data, e0.data);
            end
        end
        if (bus2.wb_valid === 1'b1) begin
            if (q2.size() == 0) chk("wb2_spurious", bus2.wb_valid, 0);
            else begin
                e2 = q2.pop_front();
                chk("wb2_rd", bus2.wb_rd, e2.rd);
                chk("wb2_data", bus2.wb_data, e2.data);
            end
        end
    end

    task automatic issue(input bit s, input logic [2:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                         input logic [RW-1:0] rs2, input logic ie, input logic [W-1:0] imm,
                         input logic [W-1:0] ea, input logic [W-1:0] eb, input logic [W-1:0] ed,
                         input string tag);
        int  n;
        int  lat;
        wb_t e;
        n = 0;
        lat = s ? 2 : 0;
        sel = s; f_op = op; f_rd = rd; f_rs1 = rs1; f_rs2 = rs2; f_ie = ie; f_imm = imm;
        if (s) v2 = 1'b1; else v0 = 1'b1;
        #1;
        while (obs_ready !== 1'b1 && n < 20) begin tick(); n++; end
        chk({tag, "_ready"}, obs_ready, 1);
        e.rd = rd; e.data = ed;
        if (s) q2.push_back(e); else q0.push_back(e);
        tick();
        v0 = 1'b0; v2 = 1'b0;
        f_imm = ~imm; f_rs1 = ~rs1; f_rs2 = ~rs2;
        for (int i = 0; i <= lat; i++) begin
            chk({tag, "_alu_a"}, obs_a, ea);
            chk({tag, "_alu_b"}, obs_b, eb);
            chk({tag, "_alu_op"}, obs_op, op);
            chk({tag, "_busy"}, obs_ready, 0);
            if (i < lat) tick();
        end
        tick();
        chk({tag, "_wb_valid"}, obs_wbv, 1);
        tick();
        chk({tag, "_ready_after"}, obs_ready, 1);
        chk({tag, "_wb_low"}, obs_wbv, 0);
    endtask

    initial begin
        rst0 = 1'b1; rst2 = 1'b1; v0 = 1'b0; v2 = 1'b0; sel = 1'b0;
        f_op = '0; f_rd = '0; f_rs1 = '0; f_rs2 = '0; f_ie = 1'b0; f_imm = '0; f_dbg = '0;
        #12;
        rst0 = 1'b0; rst2 = 1'b0;
        tick();

        // Reset state
        chk("rst_ready0", bus0.instr_ready, 1);
        chk("rst_ready2", bus2.instr_ready, 1);
        chk("rst_wbv0", bus0.wb_valid, 0);
        chk("rst_zero0", bus0.zero_flag, 0);
        chk("rst_alu0", {bus0.alu_a, bus0.alu_b, 5'd0, bus0.alu_op}, 0);
        chk("rst_wbd0", {bus0.wb_rd, bus0.wb_data}, 0);
        for (int i = 0; i < 4; i++) begin
            f_dbg = RW'(i);
            #1;
            chk("rst_rf0", bus0.dbg_data, 0);
            chk("rst_rf2", bus2.dbg_data, 0);
        end
        tick();

        // ADD imm, then dbg visibility of the write
        issue(0, 3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h00, 8'h05, 8'h05, "add");
        f_dbg = 2'd1; #1;
        chk("add_rf1", bus0.dbg_data, 8'h05);

        // SUB wrap, SUB to zero, EQ
        issue(0, 3'd1, 2'd2, 2'd1, 2'd0, 1'b1, 8'h06, 8'h05, 8'h06, 8'hFF, "sub_imm");
        chk("sub_imm_zero", bus0.zero_flag, 0);
        issue(0, 3'd1, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00, 8'h05, 8'h05, 8'h00, "sub_rr");
        chk("sub_rr_zero", bus0.zero_flag, 1);
        issue(0, 3'd7, 2'd0, 2'd2, 2'd2, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'hFF, "eq");
        chk("eq_zero", bus0.zero_flag, 0);
        f_dbg = 2'd0; #1;
        chk("eq_rf0", bus0.dbg_data, 8'hFF);

        // valid held for 6 cycles: accepts only in IDLE, cycles 0 and 3
        sel = 1'b0; f_op = 3'd4; f_rd = 2'd3; f_rs1 = 2'd1; f_rs2 = 2'd0; f_ie = 1'b1; f_imm = 8'h0F;
        e0.rd = 2'd3; e0.data = 8'h0A;
        q0.push_back(e0); q0.push_back(e0);
        tick();
        v0 = 1'b1; hs = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("hold_ready", bus0.instr_ready, (i % 3 == 0));
            if (bus0.instr_ready === 1'b1) hs++;
            tick();
        end
        v0 = 1'b0;
        chk("hold_handshakes", hs, 2);
        f_dbg = 2'd3; #1;
        chk("hold_rf3", bus0.dbg_data, 8'h0A);
        chk("hold_q_empty", q0.size(), 0);

        // ALU_LATENCY = 2
        tick();
        issue(1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h00, 8'h05, 8'h05, "l2_add");
        issue(1, 3'd5, 2'd2, 2'd1, 2'd0, 1'b1, 8'h03, 8'h05, 8'h03, 8'h28, "l2_shl");
        f_dbg = 2'd2; #1;
        chk("l2_rf2", bus2.dbg_data, 8'h28);
        chk("l2_q_empty", q2.size(), 0);

        // Reset during EXEC aborts the instruction and clears the rf
        tick();
        sel = 1'b0; f_op = 3'd0; f_rd = 2'd1; f_rs1 = 2'd1; f_ie = 1'b1; f_imm = 8'h01;
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        chk("abort_exec_a", bus0.alu_a, 8'h05);
        #2 rst0 = 1'b1;
        #2;
        chk("abort_alu_a", bus0.alu_a, 0);
        chk("abort_alu_b", bus0.alu_b, 0);
        chk("abort_ready", bus0.instr_ready, 1);
        rst0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_wb", bus0.wb_valid, 0);
        end
        chk("abort_ready_after", bus0.instr_ready, 1);
        chk("abort_zero", bus0.zero_flag, 0);
        for (int i = 0; i < 4; i++) begin
            f_dbg = RW'(i);
            #1;
            chk("abort_rf", bus0.dbg_data, 0);
        end
        chk("abort_rf2_kept", bus2.dbg_data, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
